// File: rtl/i2c_seq_pkg.sv
// Shared constants and types for the I2C register-access sequencer that drives a
// WISHBONE I2C master core (PRER/CTR/TXR/RXR/CR/SR register map).
package i2c_seq_pkg;

    localparam logic [2:0] ADR_PRERLO = 3'd0;
    localparam logic [2:0] ADR_PRERHI = 3'd1;
    localparam logic [2:0] ADR_CTR    = 3'd2;
    localparam logic [2:0] ADR_TXR    = 3'd3;
    localparam logic [2:0] ADR_RXR    = 3'd3;
    localparam logic [2:0] ADR_CR     = 3'd4;
    localparam logic [2:0] ADR_SR     = 3'd4;

    localparam logic [7:0] CR_STA_WR      = 8'h90;
    localparam logic [7:0] CR_WR          = 8'h10;
    localparam logic [7:0] CR_WR_STO      = 8'h50;
    localparam logic [7:0] CR_RD_NACK_STO = 8'h68;
    localparam logic [7:0] CR_STO         = 8'h40;
    localparam logic [7:0] CTR_EN         = 8'h80;

    localparam int SR_RXACK = 7;
    localparam int SR_AL    = 5;
    localparam int SR_TIP   = 1;

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_STEP, ST_POLL, ST_STOP, ST_RESP} seq_state_e;

    typedef enum logic [1:0] {
        ERR_OK   = 2'b00,
        ERR_NACK = 2'b01,
        ERR_AL   = 2'b10,
        ERR_TMO  = 2'b11
    } rsp_err_e;

    typedef struct packed {
        logic       rnw;
        logic [6:0] dev;
        logic [7:0] radr;
        logic [7:0] wdata;
    } seq_req_t;

    typedef struct packed {
        logic       we;
        logic [2:0] adr;
        logic [7:0] dat;
    } wb_req_t;

endpackage

// File: rtl/i2c_seq_wb_access.sv
// Single WISHBONE master access per start pulse; done pulses in the cycle after ack
// with the read data captured, which also gives the idle cycle between accesses.
import i2c_seq_pkg::*;

module i2c_seq_wb_access (
    input  logic       wb_clk_i,
    input  logic       arst_i,
    input  logic       start,
    input  wb_req_t    req,
    output logic       done,
    output logic [7:0] rdata,
    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    output logic       wbm_we_o,
    output logic       wbm_stb_o,
    output logic       wbm_cyc_o,
    input  logic       wbm_ack_i
);

    assign wbm_stb_o = wbm_cyc_o;

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            done      <= 1'b0;
            rdata     <= '0;
        end else begin
            done <= 1'b0;
            if (wbm_cyc_o) begin
                if (wbm_ack_i) begin
                    wbm_cyc_o <= 1'b0;
                    wbm_we_o  <= 1'b0;
                    done      <= 1'b1;
                    rdata     <= wbm_dat_i;
                end
            end else if (start) begin
                wbm_cyc_o <= 1'b1;
                wbm_we_o  <= req.we;
                wbm_adr_o <= req.adr;
                wbm_dat_o <= req.dat;
            end
        end
    end

endmodule

// File: rtl/i2c_wb_sequencer.sv
// Turns single-register I2C read/write requests into I2C core command sequences.
// Define I2C_SEQ_TIMEOUT_EN to bound SR polling per step to POLL_LIMIT reads (err 11).
import i2c_seq_pkg::*;

module i2c_wb_sequencer #(
    parameter logic [15:0] PRESCALE   = 16'h0063,
    parameter logic [15:0] POLL_LIMIT = 16'd4096
) (
    input  logic       wb_clk_i,
    input  logic       arst_i,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rnw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    output logic       wbm_we_o,
    output logic       wbm_stb_o,
    output logic       wbm_cyc_o,
    input  logic       wbm_ack_i
);

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    seq_state_e  state;
    seq_req_t    req_q;
    wb_req_t     acc_q;
    logic        acc_start, acc_done, busy, phase, in_stop;
    logic [7:0]  acc_rdata;
    logic [1:0]  init_idx;
    logic [2:0]  step;
    logic [15:0] poll_cnt;
    logic [7:0]  step_txr, step_cr;
    logic        step_has_txr, step_last, poll_hit;

    i2c_seq_wb_access u_wb (
        .wb_clk_i (wb_clk_i),  .arst_i    (arst_i),
        .start    (acc_start), .req       (acc_q),
        .done     (acc_done),  .rdata     (acc_rdata),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o (wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_we_o (wbm_we_o),  .wbm_stb_o (wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_ack_i(wbm_ack_i)
    );

    // Step 3 (read only) is a bare CR command; step 4 is the RXR fetch.
    always_comb begin
        step_txr     = 8'h00;
        step_cr      = CR_RD_NACK_STO;
        step_has_txr = 1'b1;
        case (step)
            3'd0: begin step_txr = {req_q.dev, 1'b0}; step_cr = CR_STA_WR; end
            3'd1: begin step_txr = req_q.radr;        step_cr = CR_WR;     end
            3'd2: begin
                step_txr = req_q.rnw ? {req_q.dev, 1'b1} : req_q.wdata;
                step_cr  = req_q.rnw ? CR_STA_WR : CR_WR_STO;
            end
            default: step_has_txr = 1'b0;
        endcase
        step_last = req_q.rnw ? (step == 3'd3) : (step == 3'd2);
        poll_hit  = (poll_cnt == POLL_LIMIT - 16'd1);
    end

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state     <= ST_INIT;
            req_q     <= '0;
            acc_q     <= '0;
            acc_start <= 1'b0;
            busy      <= 1'b0;
            phase     <= 1'b0;
            in_stop   <= 1'b0;
            init_idx  <= '0;
            step      <= '0;
            poll_cnt  <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= ERR_OK;
        end else begin
            acc_start <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (!busy) begin
                        acc_start <= 1'b1;
                        busy      <= 1'b1;
                        case (init_idx)
                            2'd0:    acc_q <= '{we: 1'b1, adr: ADR_PRERLO, dat: PRESCALE[7:0]};
                            2'd1:    acc_q <= '{we: 1'b1, adr: ADR_PRERHI, dat: PRESCALE[15:8]};
                            default: acc_q <= '{we: 1'b1, adr: ADR_CTR,    dat: CTR_EN};
                        endcase
                    end else if (acc_done) begin
                        busy <= 1'b0;
                        if (init_idx == 2'd2) begin
                            state     <= ST_IDLE;
                            req_ready <= 1'b1;
                        end else begin
                            init_idx <= init_idx + 2'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_q     <= '{rnw: req_rnw, dev: req_dev, radr: req_reg, wdata: req_wdata};
                        req_ready <= 1'b0;
                        step      <= '0;
                        phase     <= 1'b0;
                        in_stop   <= 1'b0;
                        poll_cnt  <= '0;
                        rsp_rdata <= '0;
                        rsp_err   <= ERR_OK;
                        state     <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (!busy) begin
                        acc_start <= 1'b1;
                        busy      <= 1'b1;
                        if (step == 3'd4)
                            acc_q <= '{we: 1'b0, adr: ADR_RXR, dat: 8'h00};
                        else if (!phase && step_has_txr)
                            acc_q <= '{we: 1'b1, adr: ADR_TXR, dat: step_txr};
                        else
                            acc_q <= '{we: 1'b1, adr: ADR_CR, dat: step_cr};
                    end else if (acc_done) begin
                        busy <= 1'b0;
                        if (step == 3'd4) begin
                            rsp_rdata <= acc_rdata;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else if (!phase && step_has_txr) begin
                            phase <= 1'b1;
                        end else begin
                            poll_cnt <= '0;
                            state    <= ST_POLL;
                        end
                    end
                end
                ST_POLL: begin
                    if (!busy) begin
                        acc_start <= 1'b1;
                        busy      <= 1'b1;
                        acc_q     <= '{we: 1'b0, adr: ADR_SR, dat: 8'h00};
                    end else if (acc_done) begin
                        busy <= 1'b0;
                        if (acc_rdata[SR_TIP]) begin
                            if (TMO_EN && poll_hit) begin
                                rsp_err   <= ERR_TMO;
                                rsp_valid <= in_stop;
                                state     <= in_stop ? ST_RESP : ST_STOP;
                            end else if (!poll_hit) begin
                                poll_cnt <= poll_cnt + 16'd1;
                            end
                        end else if (in_stop) begin
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else if (acc_rdata[SR_AL]) begin
                            // Arbitration lost: the bus belongs to someone else, so no STOP.
                            rsp_err   <= ERR_AL;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else if (acc_rdata[SR_RXACK] && step_cr != CR_RD_NACK_STO) begin
                            rsp_err <= ERR_NACK;
                            state   <= ST_STOP;
                        end else if (step_last && !req_q.rnw) begin
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            step     <= step_last ? 3'd4 : step + 3'd1;
                            phase    <= 1'b0;
                            poll_cnt <= '0;
                            state    <= ST_STEP;
                        end
                    end
                end
                ST_STOP: begin
                    if (!busy) begin
                        acc_start <= 1'b1;
                        busy      <= 1'b1;
                        acc_q     <= '{we: 1'b1, adr: ADR_CR, dat: CR_STO};
                    end else if (acc_done) begin
                        busy     <= 1'b0;
                        in_stop  <= 1'b1;
                        poll_cnt <= '0;
                        state    <= ST_POLL;
                    end
                end
                ST_RESP: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Scoreboard bench for i2c_wb_sequencer with a behavioural I2C-core WB slave.
module tb_i2c_wb_sequencer;

    logic       clk = 1'b0, arst_n = 1'b0;
    logic       req_valid = 1'b0, req_rnw = 1'b0;
    logic [6:0] req_dev = '0;
    logic [7:0] req_reg = '0, req_wdata = '0;
    logic       req_ready, rsp_valid, wbm_we_o, wbm_stb_o, wbm_cyc_o;
    logic [7:0] rsp_rdata, wbm_dat_o;
    logic [1:0] rsp_err;
    logic [2:0] wbm_adr_o;
    logic [7:0] dat_i = '0;
    logic       ack = 1'b0;

    always #5 clk = ~clk;

    i2c_wb_sequencer #(.PRESCALE(16'h0063), .POLL_LIMIT(16'd8)) dut (
        .wb_clk_i(clk), .arst_i(arst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(dat_i),
        .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_ack_i(ack)
    );

    int n_run = 0, n_fail = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected WB accesses {we,adr,dat} (SR polls excluded) and responses {rdata,err}.
    logic [11:0] exp_q[$];
    logic [9:0]  exp_rsp[$];

    int tip_polls = 2, tip_cnt = 0, cr_idx = 0, nack_step = -1, al_step = -1;
    int sr_total = 0, sr_reads = 0, sr_at_stop = -1;
    bit tip_stuck = 1'b0, rsp_prev = 1'b0;
    logic [7:0] sr_final = 8'h00, rxr_val = 8'h3C;

    task automatic push_exp(logic we, logic [2:0] adr, logic [7:0] dat);
        exp_q.push_back({we, adr, dat});
    endtask

    task automatic pop_check(logic [11:0] got);
        if (exp_q.size() == 0) check("wb_extra_access", 32'(exp_q.size()), 32'd1);
        else check("wb_access", 32'(got), 32'(exp_q.pop_front()));
    endtask

    task automatic push_init();
        push_exp(1'b1, 3'd0, 8'h63);
        push_exp(1'b1, 3'd1, 8'h00);
        push_exp(1'b1, 3'd2, 8'h80);
    endtask

    task automatic push_write(logic [6:0] dev, logic [7:0] r, logic [7:0] wd);
        push_exp(1'b1, 3'd3, {dev, 1'b0}); push_exp(1'b1, 3'd4, 8'h90);
        push_exp(1'b1, 3'd3, r);           push_exp(1'b1, 3'd4, 8'h10);
        push_exp(1'b1, 3'd3, wd);          push_exp(1'b1, 3'd4, 8'h50);
    endtask

    task automatic begin_txn();
        cr_idx = 0; sr_total = 0; sr_at_stop = -1;
        nack_step = -1; al_step = -1; tip_stuck = 1'b0;
    endtask

    // I2C core model: ack one negedge after stb, SR drops TIP after tip_polls reads.
    always @(negedge clk) begin
        if (!(wbm_stb_o && wbm_cyc_o)) begin
            ack = 1'b0;
        end else if (!ack) begin
            ack = 1'b1;
            if (wbm_we_o) begin
                if (wbm_adr_o == 3'd4) begin
                    if (wbm_dat_o == 8'h40) begin
                        tip_cnt = 0; sr_final = 8'h00; sr_at_stop = sr_reads;
                    end else begin
                        tip_cnt  = tip_stuck ? 1000000 : tip_polls;
                        sr_final = (cr_idx == nack_step) ? 8'h80 : (cr_idx == al_step) ? 8'h20 : 8'h00;
                        cr_idx++;
                    end
                    sr_reads = 0;
                end
                pop_check({1'b1, wbm_adr_o, wbm_dat_o});
            end else if (wbm_adr_o == 3'd4) begin
                sr_total++; sr_reads++;
                if (tip_cnt > 0) begin tip_cnt--; dat_i = 8'h02; end
                else dat_i = sr_final;
            end else begin
                dat_i = (wbm_adr_o == 3'd3) ? rxr_val : 8'h00;
                pop_check({1'b0, wbm_adr_o, 8'h00});
            end
        end
        if (rsp_valid) begin
            check("rsp_pulse_width", 32'(rsp_prev), 32'd0);
            if (exp_rsp.size() == 0) check("rsp_unexpected", 32'(exp_rsp.size()), 32'd1);
            else begin
                logic [9:0] e;
                e = exp_rsp.pop_front();
                check("rsp_rdata", 32'(rsp_rdata), 32'(e[9:2]));
                check("rsp_err", 32'(rsp_err), 32'(e[1:0]));
            end
        end
        rsp_prev = rsp_valid;
    end

    task automatic send(bit rnw, logic [6:0] dev, logic [7:0] r, logic [7:0] wd, int exp_left);
        req_rnw = rnw; req_dev = dev; req_reg = r; req_wdata = wd; req_valid = 1'b1;
        for (int i = 0; i < 2000 && !req_ready; i++) @(negedge clk);
        check("req_accept", 32'(req_ready), 32'd1);
        if (exp_left >= 0) check("init_before_ready", 32'(exp_q.size()), 32'(exp_left));
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(string tag);
        for (int i = 0; i < 4000 && exp_rsp.size() != 0; i++) @(negedge clk);
        check({tag, "_rsp_seen"}, 32'(exp_rsp.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_stb", 32'(wbm_stb_o), 32'd0);
        check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("rst_we", 32'(wbm_we_o), 32'd0);
        check("rst_adr", 32'(wbm_adr_o), 32'd0);
        check("rst_dat", 32'(wbm_dat_o), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);

        // Init, with a write request already pending while INIT runs.
        push_init();
        push_write(7'h50, 8'h10, 8'hA5);
        exp_rsp.push_back({8'h00, 2'b00});
        begin_txn();
        arst_n = 1'b1;
        send(1'b0, 7'h50, 8'h10, 8'hA5, 6);
        wait_done("write");
        check("write_sr_polls", 32'(sr_total), 32'd9);

        // Register read.
        begin_txn();
        push_exp(1'b1, 3'd3, 8'hA0); push_exp(1'b1, 3'd4, 8'h90);
        push_exp(1'b1, 3'd3, 8'h02); push_exp(1'b1, 3'd4, 8'h10);
        push_exp(1'b1, 3'd3, 8'hA1); push_exp(1'b1, 3'd4, 8'h90);
        push_exp(1'b1, 3'd4, 8'h68); push_exp(1'b0, 3'd3, 8'h00);
        exp_rsp.push_back({8'h3C, 2'b00});
        send(1'b1, 7'h50, 8'h02, 8'h00, -1);
        wait_done("read");

        // NACK on the address byte: STOP issued, err 01.
        begin_txn(); nack_step = 0;
        push_exp(1'b1, 3'd3, 8'hA0); push_exp(1'b1, 3'd4, 8'h90); push_exp(1'b1, 3'd4, 8'h40);
        exp_rsp.push_back({8'h00, 2'b01});
        send(1'b0, 7'h50, 8'h10, 8'h5A, -1);
        wait_done("nack");

        // Arbitration lost: no STOP, err 10.
        begin_txn(); al_step = 0;
        push_exp(1'b1, 3'd3, 8'hA0); push_exp(1'b1, 3'd4, 8'h90);
        exp_rsp.push_back({8'h00, 2'b10});
        send(1'b0, 7'h50, 8'h10, 8'h5A, -1);
        wait_done("arb_lost");
        repeat (20) @(negedge clk);
        check("arb_lost_no_stop", 32'(exp_q.size()), 32'd0);

        // NACK on the repeated-start read address: rdata stays 0.
        begin_txn(); nack_step = 2; rxr_val = 8'hC3;
        push_exp(1'b1, 3'd3, 8'hA0); push_exp(1'b1, 3'd4, 8'h90);
        push_exp(1'b1, 3'd3, 8'h07); push_exp(1'b1, 3'd4, 8'h10);
        push_exp(1'b1, 3'd3, 8'hA1); push_exp(1'b1, 3'd4, 8'h90);
        push_exp(1'b1, 3'd4, 8'h40);
        exp_rsp.push_back({8'h00, 2'b01});
        send(1'b1, 7'h50, 8'h07, 8'h00, -1);
        wait_done("read_nack");

`ifdef I2C_SEQ_TIMEOUT_EN
        begin_txn(); tip_stuck = 1'b1;
        push_exp(1'b1, 3'd3, 8'hA0); push_exp(1'b1, 3'd4, 8'h90); push_exp(1'b1, 3'd4, 8'h40);
        exp_rsp.push_back({8'h00, 2'b11});
        send(1'b0, 7'h50, 8'h10, 8'hA5, -1);
        wait_done("timeout");
        check("timeout_sr_polls", 32'(sr_at_stop), 32'd8);
`else
        // Polling is unbounded: 20 busy reads per step exceed POLL_LIMIT harmlessly.
        begin_txn(); tip_polls = 20;
        push_write(7'h50, 8'h10, 8'hA5);
        exp_rsp.push_back({8'h00, 2'b00});
        send(1'b0, 7'h50, 8'h10, 8'hA5, -1);
        wait_done("long_poll");
        check("long_poll_sr_polls", 32'(sr_total), 32'd63);
`endif

        // Reset during POLL: no response, INIT repeats.
        begin_txn(); tip_polls = 50;
        push_write(7'h50, 8'h10, 8'hA5);
        send(1'b0, 7'h50, 8'h10, 8'hA5, -1);
        for (int i = 0; i < 2000 && sr_total < 5; i++) @(negedge clk);
        check("rst_reached_poll", 32'(sr_total >= 5), 32'd1);
        #2 arst_n = 1'b0;
        #1;
        check("midrst_stb", 32'(wbm_stb_o), 32'd0);
        check("midrst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        push_init();
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 2000 && !req_ready; i++) @(negedge clk);
        check("reinit_done", 32'(exp_q.size()), 32'd0);

        // Recovery after reset.
        begin_txn(); tip_polls = 2;
        push_write(7'h23, 8'hFF, 8'h00);
        exp_rsp.push_back({8'h00, 2'b00});
        send(1'b0, 7'h23, 8'hFF, 8'h00, -1);
        wait_done("recover");

        check("scoreboard_drained", 32'(exp_q.size() + exp_rsp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_wb_sequencer.md
I2C_WB_SEQUENCER -- requirements
Module: i2c_wb_sequencer

Interface
REQ-001 PRESCALE, default 16'h0063, SCL prescale value written to the I2C core at init.
REQ-002 POLL_LIMIT, default 16'd4096, maximum SR polls per byte step (used only when I2C_SEQ_TIMEOUT_EN is defined).
REQ-003 wb_clk_i  in  1  single clock; every flop is clocked on its rising edge.
REQ-004 arst_i  in  1  asynchronous, active-low reset.
REQ-005 req_valid / req_ready  in / out  1 / 1  transaction request handshake.
REQ-006 req_rnw  in  1  1 = register read, 0 = register write.
REQ-007 req_dev  in  7  I2C device address; req_reg  in  8  register address; req_wdata  in  8  write data.
REQ-008 rsp_valid  out  1  response pulse; rsp_rdata  out  8  read data; rsp_err  out  2  status (00 ok, 01 NACK, 10 arbitration lost, 11 timeout).
REQ-009 wbm_adr_o  out  3; wbm_dat_o  out  8; wbm_dat_i  in  8; wbm_we_o, wbm_stb_o, wbm_cyc_o  out  1; wbm_ack_i  in  1. These form the WISHBONE master to the I2C core.

Function
REQ-010 Core register map: 0 PRERlo, 1 PRERhi, 2 CTR, 3 TXR (write) / RXR (read), 4 CR (write) / SR (read).
REQ-011 WB access: stb and cyc rise together, are held with stable adr/dat/we until wbm_ack_i, and drop the cycle after ack; one access is outstanding at a time, with at least one idle cycle between accesses.
REQ-012 Top FSM states: INIT, IDLE, STEP, POLL, STOP, RESP.
REQ-013 INIT writes PRESCALE[7:0] to addr 0, then PRESCALE[15:8] to addr 1, then 8'h80 to addr 2, then enters IDLE.
REQ-014 req_ready is high only in IDLE; a request is accepted on req_valid && req_ready, and all req_* fields are captured that cycle.
REQ-015 Write transaction steps:
- TXR={dev,0}, CR=8'h90
- TXR=reg, CR=8'h10
- TXR=wdata, CR=8'h50
REQ-016 Read transaction steps:
- TXR={dev,0}, CR=8'h90
- TXR=reg, CR=8'h10
- TXR={dev,1}, CR=8'h90
- CR=8'h68
- then read RXR (addr 3) into rsp_rdata.
REQ-017 After each CR write the FSM enters POLL and reads SR repeatedly while SR[1] (TIP) = 1.
REQ-018 With TIP = 0, SR is evaluated with this priority:
- SR[5] (AL) = 1: go to RESP with err 10 and issue no STOP.
- Else SR[7] (RxACK) = 1 on any write step: go to STOP, err 01.
- Else continue to the next step.
REQ-019 STOP writes CR=8'h40, polls until TIP = 0, then goes to RESP.
REQ-020 RESP drives rsp_valid for exactly one cycle with rsp_rdata/rsp_err valid, then returns to IDLE; rsp_rdata = 0 for writes and for errors.
REQ-021 A request presented during INIT is not accepted until init completes.

Reset
REQ-022 While arst_i = 0, outputs are:
- wbm_stb_o, wbm_cyc_o, wbm_we_o = 0
- wbm_adr_o = 0, wbm_dat_o = 0
- req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
- FSM = INIT, poll counter = 0.
REQ-023 Reset asserted mid-transaction aborts it without a response; after release, INIT is re-run in full.

Configuration
REQ-024 With I2C_SEQ_TIMEOUT_EN defined:
- A per-step poll counter is cleared on every step entry.
- Reaching POLL_LIMIT consecutive TIP = 1 reads leads to STOP with err 11.
REQ-025 With I2C_SEQ_TIMEOUT_EN undefined, polling is unbounded and err 11 is never produced.

Structure
REQ-026 Package i2c_seq_pkg holds:
- register address constants
- CR command constants (STA_WR 8'h90, WR 8'h10, WR_STO 8'h50, RD_NACK_STO 8'h68, STO 8'h40)
- SR bit indices
- the FSM state enum
- the rsp_err enum.
REQ-027 Sub-module i2c_seq_wb_access performs one WB read or write per start pulse and returns done plus read data.

Verification
REQ-028 Init: PRESCALE=16'h0063, then release reset. Required: WB writes (0,63),(1,00),(2,80) in order, then req_ready=1.
REQ-029 Write: dev 7'h50, reg 8'h10, data 8'hA5, slave ACKs all bytes. Required: TXR A0/10/A5, CR 90/10/50, rsp_err=00.
REQ-030 Read: dev 7'h50, reg 8'h02, RXR model returns 8'h3C. Required: TXR A0/02/A1, CR 90/10/90/68, rsp_rdata=3C, rsp_err=00.
REQ-031 NACK: SR returns 8'h80 after the first step. Required: CR=40 written, rsp_err=01. Arbitration lost: SR returns 8'h20. Required: no CR write, rsp_err=10.
REQ-032 TIP stuck at 1 with I2C_SEQ_TIMEOUT_EN and POLL_LIMIT=8. Required: 8 SR reads, then CR=40, rsp_err=11.
REQ-033 arst_i pulsed low during POLL. Required: stb/cyc low immediately, no rsp_valid, and the INIT sequence repeats.
